// File: rtl/wb_commit_unit_pkg.sv
// Shared definitions for the writeback/commit stage: source-select encodings,
// default widths and the hardwired-zero register index.
package wb_commit_unit_pkg;

   typedef enum logic [1:0] {
      WB_SRC_ALU = 2'd0,
      WB_SRC_MEM = 2'd1,
      WB_SRC_PC4 = 2'd2,
      WB_SRC_IMM = 2'd3
   } wb_src_e;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 5;
   localparam int unsigned REG_ZERO   = 0;

endpackage

// File: rtl/wb_commit_unit_regfile.sv
// Architectural register file: async-reset storage, one write port and two
// combinational read ports with write-through forwarding; x0 reads as zero.
module wb_regfile
   import wb_commit_unit_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned NREG   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2
);

   logic [DATA_W-1:0] regs [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && wa != ADDR_W'(REG_ZERO)) begin
         regs[wa] <= wd;
      end
   end

   // A non-zero read address matching the write address implies the write is real.
   always_comb begin
      rd1 = '0;
      if (ra1 != ADDR_W'(REG_ZERO)) rd1 = (we && wa == ra1) ? wd : regs[ra1];
   end

   always_comb begin
      rd2 = '0;
      if (ra2 != ADDR_W'(REG_ZERO)) rd2 = (we && wa == ra2) ? wd : regs[ra2];
   end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: selects writeback data, commits it to the register
// file, counts retired instructions and latches the halt condition.
module wb_commit_unit
   import wb_commit_unit_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned NREG   = 32,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              RF_WE_IN,
   input  logic [1:0]        MREWR_MUX_IN,
   input  logic              NUMINSTADD_IN,
   input  logic              HALT_IN,
   input  logic [ADDR_W-1:0] WB_RD_IN,
   input  logic [DATA_W-1:0] ALU_RES_IN,
   input  logic [DATA_W-1:0] MEM_RDATA_IN,
   input  logic [DATA_W-1:0] PC_PLUS4_IN,
   input  logic [DATA_W-1:0] IMM_IN,
   input  logic [ADDR_W-1:0] RA1_IN,
   input  logic [ADDR_W-1:0] RA2_IN,
   output logic [DATA_W-1:0] RD1_OUT,
   output logic [DATA_W-1:0] RD2_OUT,
   output logic [DATA_W-1:0] WB_DATA_OUT,
   output logic [CNT_W-1:0]  NUM_INST_OUT,
   output logic              HALTED_OUT
);

   logic             halted_q;
   logic [CNT_W-1:0] cnt_q;
   logic             commit_en;
   logic             wr_en;
   wb_src_e          src;

   assign commit_en = !halted_q;
   // RESET also gates the write so forwarding cannot leak data while in reset.
   assign wr_en     = RF_WE_IN && commit_en && !RESET;
   assign src       = wb_src_e'(MREWR_MUX_IN);

   always_comb begin
      WB_DATA_OUT = ALU_RES_IN;
      unique case (src)
         WB_SRC_ALU: WB_DATA_OUT = ALU_RES_IN;
         WB_SRC_MEM: WB_DATA_OUT = MEM_RDATA_IN;
         WB_SRC_PC4: WB_DATA_OUT = PC_PLUS4_IN;
         WB_SRC_IMM: WB_DATA_OUT = IMM_IN;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt_q    <= '0;
         halted_q <= 1'b0;
      end else if (commit_en && NUMINSTADD_IN) begin
         cnt_q <= cnt_q + CNT_W'(1);
         if (HALT_IN) halted_q <= 1'b1;
      end
   end

   assign NUM_INST_OUT = cnt_q;
   assign HALTED_OUT   = halted_q;

   wb_regfile #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NREG   (NREG)
   ) u_regfile (
      .clk (CLK),
      .rst (RESET),
      .we  (wr_en),
      .wa  (WB_RD_IN),
      .wd  (WB_DATA_OUT),
      .ra1 (RA1_IN),
      .ra2 (RA2_IN),
      .rd1 (RD1_OUT),
      .rd2 (RD2_OUT)
   );

endmodule

// File: tb/tb_wb_commit_unit.sv
// Randomized and directed bench for wb_commit_unit against a behavioural model
// of the register file, retire counter and halt latch.
module tb_wb_commit_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        rf_we;
   logic [1:0]  mux;
   logic        num;
   logic        halt;
   logic [4:0]  wb_rd;
   logic [31:0] alu, mem, pc4, imm;
   logic [4:0]  ra1, ra2;
   logic [31:0] rd1, rd2, wb_data, cnt;
   logic        halted;
   logic [31:0] rd1_n4, rd2_n4, wb_data_n4;
   logic [3:0]  cnt4;
   logic        halted_n4;

   always #5 clk = ~clk;

   wb_commit_unit dut (
      .CLK(clk), .RESET(rst), .RF_WE_IN(rf_we), .MREWR_MUX_IN(mux),
      .NUMINSTADD_IN(num), .HALT_IN(halt), .WB_RD_IN(wb_rd),
      .ALU_RES_IN(alu), .MEM_RDATA_IN(mem), .PC_PLUS4_IN(pc4), .IMM_IN(imm),
      .RA1_IN(ra1), .RA2_IN(ra2), .RD1_OUT(rd1), .RD2_OUT(rd2),
      .WB_DATA_OUT(wb_data), .NUM_INST_OUT(cnt), .HALTED_OUT(halted)
   );

   wb_commit_unit #(.CNT_W(4)) dut4 (
      .CLK(clk), .RESET(rst), .RF_WE_IN(rf_we), .MREWR_MUX_IN(mux),
      .NUMINSTADD_IN(num), .HALT_IN(halt), .WB_RD_IN(wb_rd),
      .ALU_RES_IN(alu), .MEM_RDATA_IN(mem), .PC_PLUS4_IN(pc4), .IMM_IN(imm),
      .RA1_IN(ra1), .RA2_IN(ra2), .RD1_OUT(rd1_n4), .RD2_OUT(rd2_n4),
      .WB_DATA_OUT(wb_data_n4), .NUM_INST_OUT(cnt4), .HALTED_OUT(halted_n4)
   );

   // Behavioural model
   logic [31:0] m_regs [32];
   logic [31:0] m_cnt;
   bit          m_halted;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a, input logic [31:0] wbv);
      if (a == 0) return 32'h0;
      if (rf_we && !m_halted && wb_rd == a) return wbv;
      return m_regs[a];
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt    = 0;
      m_halted = 0;
   endtask

   task automatic apply(input logic we_v, input logic [1:0] mux_v, input logic num_v,
                        input logic halt_v, input logic [4:0] rd_v,
                        input logic [31:0] alu_v, mem_v, pc4_v, imm_v,
                        input logic [4:0] ra1_v, ra2_v);
      logic [31:0] srcs [4];
      logic [31:0] exp_wb;
      @(negedge clk);
      rf_we = we_v; mux = mux_v; num = num_v; halt = halt_v; wb_rd = rd_v;
      alu = alu_v; mem = mem_v; pc4 = pc4_v; imm = imm_v; ra1 = ra1_v; ra2 = ra2_v;
      srcs   = '{alu_v, mem_v, pc4_v, imm_v};
      exp_wb = srcs[mux_v];
      #1;
      check("wb_data", wb_data, exp_wb);
      check("rd1", rd1, m_read(ra1_v, exp_wb));
      check("rd2", rd2, m_read(ra2_v, exp_wb));
      check("count", cnt, m_cnt);
      check("count4", {28'h0, cnt4}, {28'h0, m_cnt[3:0]});
      check("halted", {31'h0, halted}, {31'h0, m_halted});
      @(posedge clk);
      if (!m_halted) begin
         if (we_v && rd_v != 0) m_regs[rd_v] = exp_wb;
         if (num_v) begin
            m_cnt++;
            if (halt_v) m_halted = 1;
         end
      end
      #1;
   endtask

   task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
      apply(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, a1, a2);
   endtask

   // Asynchronous reset asserted mid-cycle with a live write presented.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rf_we = 1'b1; wb_rd = 5'd9; mux = 2'd0; alu = 32'hA5A5_A5A5; num = 1'b1;
      rst = 1'b1;
      m_clear();
      #1;
      check("rst_count", cnt, 32'h0);
      check("rst_halted", {31'h0, halted}, 32'h0);
      for (int a = 0; a < 32; a++) begin
         ra1 = 5'(a); ra2 = 5'(31 - a);
         #0.1;
         if (a % 8 == 0) begin
            check("rst_rd1", rd1, 32'h0);
            check("rst_rd2", rd2, 32'h0);
         end
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      rf_we = 1'b0; num = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rf_we = 0; mux = 0; num = 0; halt = 0; wb_rd = 0;
      alu = 0; mem = 0; pc4 = 0; imm = 0; ra1 = 0; ra2 = 0;
      m_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Each source select stored and read back
      apply(1, 2'd0, 1, 0, 5'd5, 32'h0000_1234, 32'h1, 32'h2, 32'h3, 5'd0, 5'd0);
      idle_read(5'd5, 5'd0);
      check("rd_alu", rd1, 32'h0000_1234);
      apply(1, 2'd1, 1, 0, 5'd6, 32'h1, 32'hBEEF_0001, 32'h2, 32'h3, 5'd0, 5'd0);
      apply(1, 2'd2, 1, 0, 5'd8, 32'h1, 32'h2, 32'h0000_1004, 32'h3, 5'd0, 5'd0);
      apply(1, 2'd3, 1, 0, 5'd10, 32'h1, 32'h2, 32'h3, 32'h7700_0000, 5'd0, 5'd0);
      idle_read(5'd6, 5'd8);
      check("rd_mem", rd1, 32'hBEEF_0001);
      check("rd_pc4", rd2, 32'h0000_1004);
      idle_read(5'd10, 5'd5);
      check("rd_imm", rd1, 32'h7700_0000);

      // x0 write discarded, during and after
      apply(1, 2'd0, 0, 0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      idle_read(5'd0, 5'd0);
      check("x0_after", rd1, 32'h0);

      // Same-cycle write-through on both ports
      apply(1, 2'd1, 0, 0, 5'd7, 32'h0, 32'h0000_CAFE, 32'h0, 32'h0, 5'd7, 5'd7);
      idle_read(5'd7, 5'd7);
      check("fwd_persist", rd2, 32'h0000_CAFE);

      // 10 retires with 3 bubbles
      do_reset();
      for (int i = 0; i < 13; i++)
         apply(0, 2'd0, (i % 4 == 3) ? 1'b0 : 1'b1, 0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      check("count10", cnt, 32'd10);

      // 4-bit counter wraps after 17 retires
      do_reset();
      for (int i = 0; i < 17; i++)
         apply(0, 2'd0, 1, 0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      check("count4_wrap", {28'h0, cnt4}, 32'd1);

      // Halt retires with its write, then everything freezes
      do_reset();
      apply(1, 2'd3, 1, 1, 5'd3, 32'h0, 32'h0, 32'h0, 32'h55, 5'd3, 5'd0);
      check("halt_latched", {31'h0, halted}, 32'd1);
      check("halt_counted", cnt, 32'd1);
      apply(1, 2'd0, 1, 0, 5'd3, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3);
      check("halt_nofwd", rd1, 32'h55);
      apply(1, 2'd0, 1, 1, 5'd4, 32'h1111_2222, 32'h0, 32'h0, 32'h0, 5'd4, 5'd3);
      check("halt_frozen_cnt", cnt, 32'd1);

      // Randomized traffic with occasional halts and resets
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic [4:0] d, a1, a2;
         if (i % 150 == 149) do_reset();
         d  = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
         apply(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 4) != 0), ($urandom_range(0, 99) == 0), d,
               $urandom, $urandom, $urandom, $urandom, a1, a2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
